div_issue_ctrl: RTL

//  EX-stage initiator for the iterative divider. Decodes DIV/DIVU in EX,

---
 rtl/div_issue_ctrl_pkg.sv | 25 ++
 rtl/div_issue_ctrl_watchdog.sv | 32 +++
 rtl/div_issue_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: state encoding,
// divide opcodes and word constants.
`default_nettype none

package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [5:0]  ALUOP_DIV  = 6'b011010;
  localparam logic [5:0]  ALUOP_DIVU = 6'b011011;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  function automatic logic is_zero(input logic [31:0] word);
    return word == ZERO_WORD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_issue_ctrl_watchdog.sv
// Busy-cycle watchdog: counts while enabled, restarts on clear, flags expiry
// once the count reaches TIMEOUT.
`default_nettype none

module div_issue_ctrl_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W     = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/div_issue_ctrl.sv
// EX-stage divide initiator: latches operands, runs the iterative divider,
// stalls the pipe until a result (or zero-divisor / watchdog abort) is ready.
`default_nettype none

module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int TIMEOUT    = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_div_i,
  input  logic        signed_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic        ex_stall_i,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_err_o
);

  if (TIMEOUT <= DIV_CYCLES) begin : g_bad_timeout
    $error("div_issue_ctrl: TIMEOUT must exceed DIV_CYCLES");
  end

  state_t      state;
  logic        signed_q;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        we_q;
  logic        annul_q;
  logic        err_q;
  logic        issue;
  logic        issue_busy;
  logic        expired;

  assign issue      = (state == ST_IDLE) && is_div_i && !flush_i;
  assign issue_busy = issue && !is_zero(reg2_i);

  div_issue_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (issue_busy),
    .enable  (state == ST_BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= ST_IDLE;
      signed_q <= 1'b0;
      opdata1  <= ZERO_WORD;
      opdata2  <= ZERO_WORD;
      hi_q     <= ZERO_WORD;
      lo_q     <= ZERO_WORD;
      we_q     <= 1'b0;
      annul_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      annul_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_busy) begin
            state    <= ST_BUSY;
            opdata1  <= reg1_i;
            opdata2  <= reg2_i;
            signed_q <= signed_i;
          end else if (issue) begin
            state <= ST_ZERO;
          end
        end
        ST_ZERO: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else begin
            hi_q  <= ZERO_WORD;
            lo_q  <= ZERO_WORD;
            we_q  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_BUSY: begin
          // Flush beats a same-cycle ready: the result belongs to a dead instruction.
          if (flush_i) begin
            annul_q <= 1'b1;
            state   <= ST_IDLE;
          end else if (div_ready_i) begin
            hi_q  <= div_result_i[63:32];
            lo_q  <= div_result_i[31:0];
            we_q  <= 1'b1;
            state <= ST_DONE;
          end else if (expired) begin
            annul_q <= 1'b1;
            err_q   <= 1'b1;
            hi_q    <= ZERO_WORD;
            lo_q    <= ZERO_WORD;
            we_q    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Parking here while EX is held keeps the same DIV from reissuing.
          if (flush_i || !ex_stall_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign div_signed_o  = signed_q;
  assign div_opdata1_o = opdata1;
  assign div_opdata2_o = opdata2;
  assign div_start_o   = (state == ST_BUSY);
  assign div_annul_o   = annul_q;
  assign stallreq_o    = issue || (state == ST_ZERO) || (state == ST_BUSY);
  assign hilo_we_o     = we_q && !flush_i;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_err_o     = err_q;

endmodule

`default_nettype wire
